// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 matrix-multiply sequencer: default widths,
// FSM state encoding, the final entry index and the result-slice helper.
package matmul_pkg;

    localparam int ELEM_W_DEF = 4;
    localparam int RES_W_DEF  = 9;

    // Index of the final element pair (C11 second term)
    localparam logic [2:0] LAST_ENTRY = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Bit offset of result entry idx (0=C00 .. 3=C11) inside the packed result
    function automatic int res_offset(input int idx, input int res_w);
        return idx * res_w;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate stage: forms element_a*element_b for the current entry,
// keeps the even-index product in the accumulator and, on the odd index,
// writes accumulator+product into the matching result entry.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic [2:0]           entry,
    input  logic [ELEM_W-1:0]    element_a,
    input  logic [ELEM_W-1:0]    element_b,
    output logic [4*RES_W-1:0]   result
);

    logic [2*ELEM_W-1:0] product_p0;
    logic [RES_W-1:0]    sum_p0;
    logic                acc_vld_p0;
    logic                wr_vld_p0;
    logic [2*ELEM_W-1:0] acc_p1;
    logic [RES_W-1:0]    res_p1 [4];

    // stage p0: unsigned product and the pair sum, both zero-extended
    assign product_p0 = (2*ELEM_W)'(element_a) * (2*ELEM_W)'(element_b);
    assign sum_p0     = RES_W'(acc_p1) + RES_W'(product_p0);
    assign acc_vld_p0 = sample_en & ~entry[0];
    assign wr_vld_p0  = sample_en &  entry[0];

    // stage p1: even index loads the accumulator, odd index commits a result entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p1 <= '0;
            for (int i = 0; i < 4; i++) begin
                res_p1[i] <= '0;
            end
        end else if (acc_vld_p0) begin
            acc_p1 <= product_p0;
        end else if (wr_vld_p0) begin
            res_p1[entry[2:1]] <= sum_p0;
        end
    end

    // Pack entries with C00 in the low bits and C11 in the high bits
    always_comb begin
        result = '0;
        for (int i = 0; i < 4; i++) begin
            result[res_offset(i, RES_W) +: RES_W] = res_p1[i];
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// 2x2 matrix-multiply sequencer. Walks entry indices 0..7 towards the
// falling-edge fetch banks, accumulates the returned element pairs into
// C00..C11 and hands the packed result over a valid/ready handshake.
// Optional build macro MATMUL_SEQ_CYCLE_CNT_EN adds run_cycles, a saturating
// count of edges spent in DONE waiting for out_ready.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic [2:0]         entry_out,
    input  logic [ELEM_W-1:0]  element_a,
    input  logic [ELEM_W-1:0]  element_b,
    output logic [4*RES_W-1:0] result,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    ,
    output logic [7:0]         run_cycles
`endif
);

    seq_state_t state;
    logic [2:0] next_entry;
    logic       sample_en;

    assign next_entry = entry_out + 3'd1;
    // The entry driven last cycle has its elements on the inputs in ISSUE and LAST
    assign sample_en  = (state == ISSUE) || (state == LAST);

    matmul_mac #(
        .ELEM_W (ELEM_W),
        .RES_W  (RES_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .entry     (entry_out),
        .element_a (element_a),
        .element_b (element_b),
        .result    (result)
    );

    // Control FSM with registered busy, out_valid and entry index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            entry_out <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    entry_out <= '0;
                    if (start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    entry_out <= next_entry;
                    if (next_entry == LAST_ENTRY) begin
                        state <= LAST;
                    end
                end
                LAST: begin
                    entry_out <= '0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    entry_out <= '0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    entry_out <= '0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Count edges spent in DONE with the consumer stalling; cleared by a new run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            run_cycles <= '0;
        end else if ((state == DONE) && !out_ready) begin
            run_cycles <= sat_inc(run_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
`timescale 1ns/1ps
module tb_matmul_sequencer;

    localparam int ELEM_W = 4;
    localparam int RES_W  = 9;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                out_ready = 1'b0;
    logic                busy;
    logic                out_valid;
    logic [2:0]          entry_out;
    logic [ELEM_W-1:0]   element_a = '0;
    logic [ELEM_W-1:0]   element_b = '0;
    logic [4*RES_W-1:0]  result;
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    logic [7:0]          run_cycles;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Matrices stored row-major: index = row*2 + col
    logic [3:0] mat_a [4];
    logic [3:0] mat_b [4];

    matmul_sequencer #(.ELEM_W(ELEM_W), .RES_W(RES_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .entry_out (entry_out),
        .element_a (element_a),
        .element_b (element_b),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
        ,
        .run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Fetch banks: entry k feeds term m=k&1 of result entry r=k>>1 (row r>>1, col r&1)
    always @(negedge clk) begin
        int k, r, i, j, m;
        k = int'(entry_out);
        r = k >> 1;
        i = r >> 1;
        j = r & 1;
        m = k & 1;
        element_a = mat_a[i*2 + m];
        element_b = mat_b[m*2 + j];
    end

    function automatic logic [8:0] calc_c(input int r);
        int i, j, v;
        i = r >> 1;
        j = r & 1;
        v = int'(mat_a[i*2]) * int'(mat_b[j]) + int'(mat_a[i*2+1]) * int'(mat_b[2+j]);
        return 9'(v);
    endfunction

    // Transaction-level model: phase -1 idle, 0..7 = edges since accept, 8 = result held
    int         m_phase = -1;
    int         m_cyc = 0;
    logic [8:0] m_res [4] = '{default: '0};
    bit         st_s, rd_s;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = -1;
            m_cyc = 0;
            for (int q = 0; q < 4; q++) m_res[q] = '0;
        end else begin
            st_s = start;
            rd_s = out_ready;
            if (m_phase == -1) begin
                if (st_s) begin
                    m_phase = 0;
                    m_cyc = 0;
                end
            end else if (m_phase < 8) begin
                m_phase++;
                if (m_phase % 2 == 0) m_res[m_phase/2 - 1] = calc_c(m_phase/2 - 1);
            end else begin
                if (rd_s) m_phase = -1;
                else if (m_cyc < 255) m_cyc++;
            end
            #1;
            if (chk_en) begin
                check("cyc_busy", busy, (m_phase != -1));
                check("cyc_out_valid", out_valid, (m_phase == 8));
                check("cyc_entry_out", entry_out, (m_phase >= 0 && m_phase < 8) ? m_phase : 0);
                check("cyc_result", result, {m_res[3], m_res[2], m_res[1], m_res[0]});
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
                check("cyc_run_cycles", run_cycles, m_cyc);
`endif
            end
        end
    end

    task automatic set_mats(input logic [15:0] a, input logic [15:0] b);
        for (int q = 0; q < 4; q++) begin
            mat_a[q] = a[q*4 +: 4];
            mat_b[q] = b[q*4 +: 4];
        end
    endtask

    // Pulse start, then count edges until out_valid while checking the index walk
    task automatic start_and_wait(output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #2;
            lat++;
            if (lat < 8) check("entry_seq", entry_out, lat);
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_fields(input string name, input int c00, input int c01, input int c10, input int c11);
        check({name, "_c00"}, result[8:0],   c00);
        check({name, "_c01"}, result[17:9],  c01);
        check({name, "_c10"}, result[26:18], c10);
        check({name, "_c11"}, result[35:27], c11);
    endtask

    initial begin
        int lat;
        int n;
        logic [35:0] snap;

        set_mats(16'h4321, 16'h8765);
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_entry_out", entry_out, 0);
        check("rst_result", result, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Basic: A=[[1,2],[3,4]] B=[[5,6],[7,8]]
        start_and_wait(lat);
        check("basic_latency", lat, 8);
        check_fields("basic", 19, 22, 43, 50);
        release_result();
        check("basic_idle_busy", busy, 0);

        // Max values: all 15 -> 2*225 = 450 per entry
        set_mats(16'hFFFF, 16'hFFFF);
        start_and_wait(lat);
        check("max_latency", lat, 8);
        check_fields("max", 450, 450, 450, 450);
        release_result();

        // Backpressure: hold out_ready low for 5 edges in DONE
        set_mats(16'h4321, 16'h8765);
        start_and_wait(lat);
        snap = result;
        repeat (5) begin
            @(posedge clk);
            #2;
            check("bp_valid", out_valid, 1);
            check("bp_busy", busy, 1);
            check("bp_entry", entry_out, 0);
            check("bp_result", result, snap);
        end
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
        check("bp_run_cycles", run_cycles, 5);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_busy", busy, 0);
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
        check("run_cycles_hold", run_cycles, 5);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        check("run_cycles_clear", run_cycles, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("cnt_run_latency", n, 8);
        release_result();
`endif

        // Start ignored during ISSUE, in DONE, and on the accepting out_ready edge
        set_mats(16'h2143, 16'h1357);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("ign_valid", out_valid, 1);
        // A=[[3,4],[1,2]] B=[[7,5],[3,1]]: 33,19,13,7
        check_fields("ign", 33, 19, 13, 7);
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("ign_idle_busy", busy, 0);
        check("ign_idle_entry", entry_out, 0);
        check_fields("ign_hold", 33, 19, 13, 7);

        // Reset mid-run after entry_out reaches 3
        set_mats(16'h4321, 16'h8765);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        n = 0;
        while (entry_out != 3'd3 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("mid_reach3", entry_out, 3);
        #1;
        rst = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_valid", out_valid, 0);
        check("mid_entry", entry_out, 0);
        check("mid_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_and_wait(lat);
        check("post_rst_latency", lat, 8);
        check_fields("post_rst", 19, 22, 43, 50);
        release_result();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
